// File: rtl/census_hamming_wta_if.sv
// rtl/census_hamming_wta_if.sv - census pair input and disparity result signal bundle
interface census_hamming_wta_if #(
  parameter int CW = 24,
  parameter int DW = 4
);
  logic          valid_in;
  logic [CW-1:0] cl;
  logic [CW-1:0] cr;
  logic [12:0]   row_in;
  logic [12:0]   col_in;
  logic          valid_out;
  logic [DW-1:0] disp_out;
  logic [4:0]    cost_out;
  logic [12:0]   row_out;
  logic [12:0]   col_out;

  modport master (
    output valid_in, cl, cr, row_in, col_in,
    input  valid_out, disp_out, cost_out, row_out, col_out
  );

  modport slave (
    input  valid_in, cl, cr, row_in, col_in,
    output valid_out, disp_out, cost_out, row_out, col_out
  );
endinterface

// File: rtl/census_hamming_wta.sv
// rtl/census_hamming_wta.sv - census Hamming cost over MAXD disparities with pipelined winner-take-all
module census_hamming_wta #(
  parameter int MAXD = 16,
  parameter int DW   = 4,
  parameter int CW   = 24
) (
  input logic                 clk,
  input logic                 rst_n,
  census_hamming_wta_if.slave bus
);

  localparam int LG = $clog2(MAXD);
  localparam int L  = 1 + LG;
  // All tree nodes in one flat array: level 0 (per-disparity costs) at
  // [0..MAXD-1], level 1 right after it, and so on down to the root at NN-1.
  localparam int NN = 2 * MAXD - 1;

  function automatic logic [4:0] popcount(input logic [CW-1:0] x);
    logic [4:0] s;
    s = '0;
    for (int k = 0; k < CW; k++) s = s + 5'(x[k]);
    return s;
  endfunction

  function automatic int lvl_base(input int l);
    return 2 * MAXD - ((2 * MAXD) >> l);
  endfunction

  logic [MAXD-1:1][CW-1:0] hist_q, hist_d;
  logic [NN-1:0][4:0]      c_q, c_d;
  logic [NN-1:0][DW-1:0]   i_q, i_d;
  logic [L:1]              v_q, v_d;
  logic [L:1][12:0]        row_q, row_d;
  logic [L:1][12:0]        col_q, col_d;

  // Next state: right history shift, masked Hamming costs, one min-tree level
  // per stage. Data registers only load behind a valid token, so bubbles leave
  // every stage (and thus the outputs) holding their last valid contents.
  always_comb begin
    hist_d = hist_q;
    c_d    = c_q;
    i_d    = i_q;
    row_d  = row_q;
    col_d  = col_q;
    v_d[1] = bus.valid_in;
    for (int s = 2; s <= L; s++) v_d[s] = v_q[s-1];

    if (bus.valid_in) begin
      hist_d[1] = bus.cr;
      for (int k = 2; k < MAXD; k++) hist_d[k] = hist_q[k-1];

      // d=0 is always eligible; farther candidates that fall off the left
      // edge of the row get a cost no real match can reach.
      c_d[0] = popcount(bus.cl ^ bus.cr);
      i_d[0] = '0;
      for (int d = 1; d < MAXD; d++) begin
        c_d[d] = (bus.col_in >= 13'(d)) ? popcount(bus.cl ^ hist_q[d]) : 5'd31;
        i_d[d] = DW'(d);
      end
      row_d[1] = bus.row_in;
      col_d[1] = bus.col_in;
    end

    for (int l = 1; l <= LG; l++) begin
      if (v_q[l]) begin
        // Left child always covers lower disparities, so it keeps ties.
        for (int n = 0; n < (MAXD >> l); n++) begin
          if (c_q[lvl_base(l-1) + 2*n + 1] < c_q[lvl_base(l-1) + 2*n]) begin
            c_d[lvl_base(l) + n] = c_q[lvl_base(l-1) + 2*n + 1];
            i_d[lvl_base(l) + n] = i_q[lvl_base(l-1) + 2*n + 1];
          end else begin
            c_d[lvl_base(l) + n] = c_q[lvl_base(l-1) + 2*n];
            i_d[lvl_base(l) + n] = i_q[lvl_base(l-1) + 2*n];
          end
        end
        row_d[l+1] = row_q[l];
        col_d[l+1] = col_q[l];
      end
    end
  end

  // State registers; reset wipes history and drops every in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      c_q    <= '0;
      i_q    <= '0;
      v_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      hist_q <= hist_d;
      c_q    <= c_d;
      i_q    <= i_d;
      v_q    <= v_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign bus.valid_out = v_q[L];
  assign bus.disp_out  = i_q[NN-1];
  assign bus.cost_out  = c_q[NN-1];
  assign bus.row_out   = row_q[L];
  assign bus.col_out   = col_q[L];

endmodule

// File: tb/tb_census_hamming_wta.sv
// tb/tb_census_hamming_wta.sv - scoreboard bench for census_hamming_wta
module tb_census_hamming_wta;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0]  disp;
    logic [4:0]  cost;
    logic [12:0] row;
    logic [12:0] col;
    int          cyc;
    int          mode;  // 0: exact disp/cost, 1: only disp <= col
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  bit   have_last = 0;

  census_hamming_wta_if #(.CW(24), .DW(4)) bus ();

  census_hamming_wta #(.MAXD(16), .DW(4), .CW(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] vf(input int c);
    return (24'(c) * 24'h9E3779) ^ 24'h5A5A5A;
  endfunction

  task automatic send(input logic v, input logic [23:0] l, input logic [23:0] r,
                      input logic [12:0] row, input logic [12:0] col, input int mode,
                      input logic [3:0] ed, input logic [4:0] ec);
    exp_t e;
    @(negedge clk);
    bus.valid_in = v;
    bus.cl       = l;
    bus.cr       = r;
    bus.row_in   = row;
    bus.col_in   = col;
    if (v) begin
      e.disp = ed; e.cost = ec; e.row = row; e.col = col;
      e.cyc  = cyc; e.mode = mode;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on each valid result, checks held outputs otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.cyc, 5);
          chk("row_out", int'(bus.row_out), int'(e.row));
          chk("col_out", int'(bus.col_out), int'(e.col));
          if (e.mode == 0) begin
            chk("disp_out", int'(bus.disp_out), int'(e.disp));
            chk("cost_out", int'(bus.cost_out), int'(e.cost));
          end else begin
            checks++;
            if (int'(bus.disp_out) > int'(e.col)) begin
              errors++;
              $display("FAIL border_disp_le_col: got disp %0d at col %0d", bus.disp_out, e.col);
            end
          end
          last_e = e;
          have_last = 1;
        end
      end else if (have_last) begin
        chk("hold_row_out", int'(bus.row_out), int'(last_e.row));
        chk("hold_col_out", int'(bus.col_out), int'(last_e.col));
        if (last_e.mode == 0) begin
          chk("hold_disp_out", int'(bus.disp_out), int'(last_e.disp));
          chk("hold_cost_out", int'(bus.cost_out), int'(last_e.cost));
        end
      end
    end
  end

  localparam logic [23:0] CB = 24'hA5C33C;

  initial begin
    bus.valid_in = 1'b0;
    bus.cl = '0; bus.cr = '0; bus.row_in = '0; bus.col_in = '0;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.valid_in = ~bus.valid_in;
      bus.cl = 24'($urandom);
      bus.cr = 24'($urandom);
      bus.col_in = 13'(i);
      #1;
      chk("rst_valid_out", int'(bus.valid_out), 0);
      chk("rst_disp_out", int'(bus.disp_out), 0);
      chk("rst_cost_out", int'(bus.cost_out), 0);
      chk("rst_row_out", int'(bus.row_out), 0);
      chk("rst_col_out", int'(bus.col_out), 0);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;

    // Single sample after reset.
    send(1, 24'h123456, 24'h123456, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) send(0, '0, '0, 0, 0, 0, 0, 0);

    // Identity.
    for (int c = 0; c < 64; c++) send(1, vf(c), vf(c), 1, 13'(c), 0, 0, 0);

    // Right image shifted by 5.
    for (int c = 0; c < 64; c++) send(1, vf(c), vf(c+5), 2, 13'(c), (c < 5) ? 1 : 0, 5, 0);

    // Same with a bubble after every sample.
    for (int c = 0; c < 64; c++) begin
      send(1, vf(c), vf(c+5), 3, 13'(c), (c < 5) ? 1 : 0, 5, 0);
      send(0, '0, '0, 0, 0, 0, 0, 0);
    end

    // All-ones versus all-zeros: every eligible cost is 24, lowest disparity wins.
    for (int c = 0; c <= 20; c++) send(1, 24'hFFFFFF, 24'h000000, 4, 13'(c), 0, 0, 24);

    // Row change: at col 2, hist[7] matches exactly but is masked; costs 9,4,4 tie low.
    send(1, CB, CB,               10, 59, 0, 0, 0);
    send(1, CB, ~CB,              10, 60, 0, 1, 0);
    send(1, CB, ~CB,              10, 61, 0, 2, 0);
    send(1, CB, ~CB,              10, 62, 0, 3, 0);
    send(1, CB, ~CB,              10, 63, 0, 4, 0);
    send(1, CB, CB ^ 24'hF00000,  11, 0,  0, 0, 4);
    send(1, CB, CB ^ 24'h00000F,  11, 1,  0, 0, 4);
    send(1, CB, CB ^ 24'h0001FF,  11, 2,  0, 1, 4);

    for (int i = 0; i < 12; i++) send(0, '0, '0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
